fcc_uf_engine: RTL and testbench
================================

Name: fcc_uf_engine

Overview:
- Parametrised union-find engine for the FCC clustering pipeline, for N = 2^LABEL_W provisional labels.
- Buffers union requests in an input FIFO and answers root queries, with optional full path compression.
- Initialises its parent table with a post-reset sweep instead of a reset loop.
- Provides a flatten pass that streams every label with a compact, consecutive cluster ID and reports the total cluster count to the relabel stage.

Parameters:
LABEL_W, 12, label width; table depth N = 2^LABEL_W
UFIFO_DEPTH, 8, union request FIFO depth (power of 2, >=2)
FULL_COMPRESS, 1, 1 = query rewrites every node on the path to the root; 0 = rewrites start node only

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
u_valid  in  1  union request valid
u_ready  out  1  FIFO can accept a request
u_a  in  LABEL_W  union operand A
u_b  in  LABEL_W  union operand B
q_valid  in  1  root query valid
q_ready  out  1  query accepted this cycle
q_label  in  LABEL_W  label to resolve
q_out_valid  out  1  one-cycle pulse, q_root valid
q_root  out  LABEL_W  root of queried label
flat_start  in  1  pulse: request flatten pass
fl_valid  out  1  flatten output valid
fl_ready  in  1  downstream accepts flatten output
fl_label  out  LABEL_W  label being reported
fl_cid  out  LABEL_W  compact cluster ID of fl_label
fl_last  out  1  marks label N-1
n_clusters  out  LABEL_W+1  root count from the last completed flatten
busy  out  1  high in any state except S_IDLE with an empty FIFO

Behaviour:
- Reset: state=S_INIT, init counter=0, FIFO empty, flat_pending=0.
- Reset values: q_out_valid=0, q_root=0, fl_valid=0, fl_label=0, fl_cid=0, fl_last=0, n_clusters=0, busy=1.
- Reset asserted mid-operation abandons all work, including FIFO contents and an in-progress flatten.
- S_INIT: writes parent[i]=i for one i per cycle over N cycles, then goes to S_IDLE. u_ready=0 and q_ready=0 throughout.
- Union FIFO: push when u_valid && u_ready. u_ready = !full && state!=S_INIT. Requests are accepted during union, query and flatten work.
- Union FIFO boundary cases: a simultaneous push and pop when full is not allowed (u_ready=0). A pop when empty never occurs.
- q_ready = (state==S_IDLE) && FIFO empty && !flat_pending && !flat_start, so every query sees all previously accepted unions.
- Priority in S_IDLE: flat_pending/flat_start when FIFO empty > FIFO pop > query.
- flat_start arriving while the FIFO is non-empty or the FSM is not idle sets flat_pending. The pending flatten runs once the FIFO has drained.
- Union path, per request:
  - S_FA walks from A, one hop per cycle, until parent[cur]==cur. It records root_a and writes parent[A]=root_a.
  - S_FB does the same from B.
  - S_UNION: if the roots differ, parent[max root] = min root. Then return to S_IDLE.
  - Invariant: parent[x] <= x always.
  - u_a==u_b, or operands already sharing a root: no merge, 3+ cycles consumed.
- Query path:
  - Accept at cycle T. S_QFIND walks h hops.
  - q_out_valid pulses at T+h+2, with q_root held until the next query.
  - FULL_COMPRESS=1: S_QCOMP then rewalks from q_label, setting parent[cur]=root for each node with cur!=root, one per cycle. q_ready stays low until it finishes.
  - FULL_COMPRESS=0: parent[q_label]=root is written in the final find cycle.
- Flatten, states S_FLAT then S_FOUT, for i = 0..N-1 ascending:
  - Let p=parent[i]. Because p<=i, p is already flat, so r=parent[p] in one lookup.
  - If r==i: i is a root, cid[i]=next_id, then next_id++.
  - Else: cid[i]=cid[r], and parent[i]=r is written.
  - Drive fl_valid with fl_label=i, fl_cid, and fl_last=(i==N-1). Hold until fl_ready, then advance.
  - After the last handshake, n_clusters=next_id (value N is possible, hence LABEL_W+1 bits), flat_pending=0, return to S_IDLE.
  - Throughput: 1 label per 2 cycles with fl_ready held high.
- cid table: separate N x LABEL_W memory, written only during flatten.

Test Plan:
- LABEL_W=4: release rst -> busy=1, u_ready=0 for 16 cycles, then u_ready=1; queries of 0..15 each return q_root = the queried label.
- Unions (3,7), (7,12), (5,12), then query 12 -> q_root=3; query 5 -> q_root=3; parent[12]==3 after query.
- FULL_COMPRESS=1: chain (2,3),(1,2),(0,1) built with merges only via roots, query 3 -> q_root=0. Immediately re-query 3 -> q_out_valid exactly 2 cycles after acceptance (h=0).
- Push 9 unions with UFIFO_DEPTH=8 while a query's compression is running -> u_ready drops after the 8th push, no request lost; later queries reflect all 9.
- After unions (3,7),(7,12),(5,12),(1,4) and flatten with fl_ready toggling 1/0 -> 16 outputs in label order; labels {0,2,6,8,9,10,11,13,14,15} get distinct cids; 1 and 4 share one cid; 3,5,7,12 share one cid; n_clusters=12; fl_last only on label 15.
- flat_start asserted with 3 unions queued -> all 3 unions applied before the first fl_valid; query issued during flatten is not accepted (q_ready=0) until flatten completes.

Source files
------------

// File: rtl/fcc_uf_engine.sv
// rtl/fcc_uf_engine.sv - union-find engine with union FIFO, root queries and flatten pass
module fcc_uf_engine #(
    parameter int LABEL_W       = 12,
    parameter int UFIFO_DEPTH   = 8,
    parameter int FULL_COMPRESS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               u_valid,
    output logic               u_ready,
    input  logic [LABEL_W-1:0] u_a,
    input  logic [LABEL_W-1:0] u_b,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [LABEL_W-1:0] q_label,
    output logic               q_out_valid,
    output logic [LABEL_W-1:0] q_root,
    input  logic               flat_start,
    output logic               fl_valid,
    input  logic               fl_ready,
    output logic [LABEL_W-1:0] fl_label,
    output logic [LABEL_W-1:0] fl_cid,
    output logic               fl_last,
    output logic [LABEL_W:0]   n_clusters,
    output logic               busy
);
    localparam int N  = 1 << LABEL_W;
    localparam int PW = $clog2(UFIFO_DEPTH);
    localparam logic [LABEL_W-1:0] LAST = '1;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_FA, S_FB, S_UNION, S_QFIND, S_QCOMP, S_FLAT, S_FOUT
    } state_t;

    logic [LABEL_W-1:0] parent_mem [N];
    logic [LABEL_W-1:0] cid_mem    [N];
    logic [LABEL_W-1:0] fa_mem     [UFIFO_DEPTH];
    logic [LABEL_W-1:0] fb_mem     [UFIFO_DEPTH];

    state_t             state_q, state_d;
    logic [LABEL_W-1:0] idx_q, idx_d, cur_q, cur_d;
    logic [LABEL_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [LABEL_W-1:0] root_a_q, root_a_d, root_b_q, root_b_d, qlab_q, qlab_d;
    logic [LABEL_W-1:0] q_root_q, q_root_d, fl_label_q, fl_label_d, fl_cid_q, fl_cid_d;
    logic               q_out_valid_q, q_out_valid_d, fl_last_q, fl_last_d;
    logic               flat_pending_q, flat_pending_d;
    logic [LABEL_W:0]   next_id_q, next_id_d, n_clusters_q, n_clusters_d;
    logic [PW:0]        wp_q, rp_q;

    logic               fifo_empty, fifo_full, push, pop;
    logic               pwe, cwe;
    logic [LABEL_W-1:0] paddr, pdata, caddr, cdata;
    logic [LABEL_W-1:0] par_cur, par_q, par_idx, par_par, cid_r;

    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign u_ready    = !fifo_full && (state_q != S_INIT);
    assign push       = u_valid && u_ready;
    assign q_ready    = (state_q == S_IDLE) && fifo_empty && !flat_pending_q && !flat_start;

    // Asynchronous table reads; parent[i] <= i lets the flatten resolve roots in two lookups.
    assign par_cur = parent_mem[cur_q];
    assign par_q   = parent_mem[q_label];
    assign par_idx = parent_mem[idx_q];
    assign par_par = parent_mem[par_idx];
    assign cid_r   = cid_mem[par_par];

    assign q_out_valid = q_out_valid_q;
    assign q_root      = q_root_q;
    assign fl_valid    = (state_q == S_FOUT);
    assign fl_label    = fl_label_q;
    assign fl_cid      = fl_cid_q;
    assign fl_last     = fl_last_q;
    assign n_clusters  = n_clusters_q;
    assign busy        = !((state_q == S_IDLE) && fifo_empty);

    always_comb begin
        state_d = state_q;  idx_d = idx_q;  cur_d = cur_q;
        op_a_d = op_a_q;  op_b_d = op_b_q;  root_a_d = root_a_q;  root_b_d = root_b_q;
        qlab_d = qlab_q;  q_root_d = q_root_q;  q_out_valid_d = 1'b0;
        fl_label_d = fl_label_q;  fl_cid_d = fl_cid_q;  fl_last_d = fl_last_q;
        next_id_d = next_id_q;  n_clusters_d = n_clusters_q;  flat_pending_d = flat_pending_q;
        pop = 1'b0;  pwe = 1'b0;  paddr = '0;  pdata = '0;  cwe = 1'b0;  caddr = '0;  cdata = '0;
        case (state_q)
            S_INIT: begin
                pwe = 1'b1;  paddr = idx_q;  pdata = idx_q;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                if ((flat_pending_q || flat_start) && fifo_empty) begin
                    idx_d = '0;  next_id_d = '0;  state_d = S_FLAT;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    op_a_d = fa_mem[rp_q[PW-1:0]];  op_b_d = fb_mem[rp_q[PW-1:0]];
                    cur_d = fa_mem[rp_q[PW-1:0]];  state_d = S_FA;
                end else if (q_valid && q_ready) begin
                    qlab_d = q_label;  cur_d = par_q;  state_d = S_QFIND;
                end
            end
            S_FA: begin
                if (par_cur == cur_q) begin
                    root_a_d = cur_q;  pwe = 1'b1;  paddr = op_a_q;  pdata = cur_q;
                    cur_d = op_b_q;  state_d = S_FB;
                end else cur_d = par_cur;
            end
            S_FB: begin
                if (par_cur == cur_q) begin
                    root_b_d = cur_q;  pwe = 1'b1;  paddr = op_b_q;  pdata = cur_q;
                    state_d = S_UNION;
                end else cur_d = par_cur;
            end
            S_UNION: begin
                if (root_a_q != root_b_q) begin
                    pwe   = 1'b1;
                    paddr = (root_a_q > root_b_q) ? root_a_q : root_b_q;
                    pdata = (root_a_q > root_b_q) ? root_b_q : root_a_q;
                end
                state_d = S_IDLE;
            end
            S_QFIND: begin
                if (par_cur == cur_q) begin
                    q_root_d = cur_q;  q_out_valid_d = 1'b1;
                    if (FULL_COMPRESS != 0) begin
                        cur_d = qlab_q;  state_d = S_QCOMP;
                    end else begin
                        pwe = 1'b1;  paddr = qlab_q;  pdata = cur_q;  state_d = S_IDLE;
                    end
                end else cur_d = par_cur;
            end
            S_QCOMP: begin
                if (cur_q != q_root_q) begin
                    pwe = 1'b1;  paddr = cur_q;  pdata = q_root_q;  cur_d = par_cur;
                end else state_d = S_IDLE;
            end
            S_FLAT: begin
                fl_label_d = idx_q;  fl_last_d = (idx_q == LAST);
                cwe = 1'b1;  caddr = idx_q;
                if (par_par == idx_q) begin
                    cdata = next_id_q[LABEL_W-1:0];  next_id_d = next_id_q + 1'b1;
                end else begin
                    cdata = cid_r;  pwe = 1'b1;  paddr = idx_q;  pdata = par_par;
                end
                fl_cid_d = cdata;  state_d = S_FOUT;
            end
            S_FOUT: begin
                if (fl_ready) begin
                    if (idx_q == LAST) begin
                        n_clusters_d = next_id_q;  flat_pending_d = 1'b0;  state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;  state_d = S_FLAT;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
        if (flat_start) flat_pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (pwe) parent_mem[paddr] <= pdata;
        if (cwe) cid_mem[caddr] <= cdata;
        if (push) begin
            fa_mem[wp_q[PW-1:0]] <= u_a;
            fb_mem[wp_q[PW-1:0]] <= u_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;  idx_q <= '0;  cur_q <= '0;  op_a_q <= '0;  op_b_q <= '0;
            root_a_q <= '0;  root_b_q <= '0;  qlab_q <= '0;  q_root_q <= '0;
            q_out_valid_q <= 1'b0;  fl_label_q <= '0;  fl_cid_q <= '0;  fl_last_q <= 1'b0;
            next_id_q <= '0;  n_clusters_q <= '0;  flat_pending_q <= 1'b0;
            wp_q <= '0;  rp_q <= '0;
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  cur_q <= cur_d;  op_a_q <= op_a_d;
            op_b_q <= op_b_d;  root_a_q <= root_a_d;  root_b_q <= root_b_d;  qlab_q <= qlab_d;
            q_root_q <= q_root_d;  q_out_valid_q <= q_out_valid_d;  fl_label_q <= fl_label_d;
            fl_cid_q <= fl_cid_d;  fl_last_q <= fl_last_d;  next_id_q <= next_id_d;
            n_clusters_q <= n_clusters_d;  flat_pending_q <= flat_pending_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_fcc_uf_engine.sv
// tb/tb_fcc_uf_engine.sv - self-checking bench for fcc_uf_engine against a set-based model
module tb_fcc_uf_engine;
    localparam int LW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          u_valid = 1'b0, q_valid = 1'b0, flat_start = 1'b0, fl_ready = 1'b0;
    logic [LW-1:0] u_a = '0, u_b = '0, q_label = '0;
    logic          u_ready, q_ready, q_out_valid, fl_valid, fl_last, busy;
    logic [LW-1:0] q_root, fl_label, fl_cid;
    logic [LW:0]   n_clusters;

    always #5 clk = ~clk;

    fcc_uf_engine #(.LABEL_W(LW), .UFIFO_DEPTH(8), .FULL_COMPRESS(1)) dut (
        .clk(clk), .rst(rst),
        .u_valid(u_valid), .u_ready(u_ready), .u_a(u_a), .u_b(u_b),
        .q_valid(q_valid), .q_ready(q_ready), .q_label(q_label),
        .q_out_valid(q_out_valid), .q_root(q_root),
        .flat_start(flat_start), .fl_valid(fl_valid), .fl_ready(fl_ready),
        .fl_label(fl_label), .fl_cid(fl_cid), .fl_last(fl_last),
        .n_clusters(n_clusters), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int m_root [N];   // each label maps to the smallest label of its set

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_root[i] = i;
    endfunction

    function automatic void m_union(input int a, input int b);
        int ra, rb, lo, hi;
        ra = m_root[a];  rb = m_root[b];
        lo = (ra < rb) ? ra : rb;  hi = (ra < rb) ? rb : ra;
        for (int i = 0; i < N; i++) if (m_root[i] == hi) m_root[i] = lo;
    endfunction

    function automatic int m_cid(input int x);
        int c = 0;
        for (int j = 0; j < m_root[x]; j++) if (m_root[j] == j) c++;
        return c;
    endfunction

    function automatic int m_nclusters();
        int c = 0;
        for (int j = 0; j < N; j++) if (m_root[j] == j) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!u_ready && n < 200) begin step(); n++; end
        check("init_done", u_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;  u_valid = 0;  q_valid = 0;  flat_start = 0;  fl_ready = 0;
        repeat (3) step();
        rst = 1'b0;
        m_reset();
        wait_ready();
    endtask

    task automatic do_union(input int a, input int b);
        int n = 0;
        u_a = LW'(a);  u_b = LW'(b);  u_valid = 1'b1;
        while (!u_ready && n < 500) begin step(); n++; end
        check("union_accept", u_ready, 1);
        step();
        u_valid = 1'b0;
        m_union(a, b);
    endtask

    task automatic do_query(input int lab, output int root, output int lat);
        int n = 0;
        q_label = LW'(lab);  q_valid = 1'b1;
        while (!q_ready && n < 500) begin step(); n++; end
        check("query_accept", q_ready, 1);
        step();
        q_valid = 1'b0;
        lat = 1;
        while (!q_out_valid && lat < 200) begin step(); lat++; end
        check("query_answer", q_out_valid, 1);
        root = int'(q_root);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin step(); n++; end
        check("idle_wait", busy, 0);
    endtask

    task automatic query_all(input string tag);
        int r, l;
        for (int i = 0; i < N; i++) begin
            do_query(i, r, l);
            check(tag, r, m_root[i]);
        end
    endtask

    task automatic run_flatten(input bit hold_q);
        int got = 0, cyc = 0, early = 0;
        flat_start = 1'b1;
        q_valid = hold_q;  q_label = LW'(9);
        while (got < N && cyc < 4000) begin
            fl_ready = (cyc % 2 == 0);
            if (hold_q && q_ready) early++;
            if (fl_valid && fl_ready) begin
                check("fl_label", fl_label, got);
                check("fl_cid", fl_cid, m_cid(got));
                check("fl_last", fl_last, (got == N - 1));
                got++;
            end
            step();
            flat_start = 1'b0;
            cyc++;
        end
        fl_ready = 1'b0;  q_valid = 1'b0;
        check("flat_count", got, N);
        if (hold_q) check("q_ready_in_flatten", early, 0);
        check("n_clusters", n_clusters, m_nclusters());
    endtask

    int r, lat, n, pushed, seen, got_root, dropchk;
    int pa [9] = '{10, 12, 11, 14, 15, 13, 5, 11, 15};
    int pb [9] = '{11, 13, 13, 10, 15, 10, 14, 12, 4};

    initial begin
        m_reset();
        repeat (3) step();
        check("rst_q_out_valid", q_out_valid, 0);
        check("rst_q_root", q_root, 0);
        check("rst_fl_valid", fl_valid, 0);
        check("rst_fl_label", fl_label, 0);
        check("rst_fl_cid", fl_cid, 0);
        check("rst_fl_last", fl_last, 0);
        check("rst_n_clusters", n_clusters, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("init_u_ready", u_ready, 0);
            check("init_q_ready", q_ready, 0);
            check("init_busy", busy, 1);
            step();
        end
        check("post_init_u_ready", u_ready, 1);
        query_all("init_root");

        do_union(3, 7);  do_union(7, 12);  do_union(5, 12);
        do_query(12, r, lat);  check("root12", r, 3);
        do_query(5, r, lat);   check("root5", r, 3);
        do_query(12, r, lat);  check("requery12_lat", lat, 2);
        do_union(1, 4);
        wait_idle();
        run_flatten(1'b0);

        do_union(8, 9);  do_union(9, 10);  do_union(0, 11);
        run_flatten(1'b1);
        do_query(9, r, lat);   check("root9_after_flat", r, m_root[9]);

        do_reset();
        for (int k = 8; k >= 0; k--) do_union(k, k + 1);
        wait_idle();
        do_query(3, r, lat);   check("chain_root3", r, 0);
        do_query(3, r, lat);   check("chain_requery3_lat", lat, 2);

        q_label = LW'(9);  q_valid = 1'b1;
        n = 0;
        while (!q_ready && n < 500) begin step(); n++; end
        check("deep_query_accept", q_ready, 1);
        step();
        q_valid = 1'b0;
        seen = 0;  pushed = 0;  n = 0;  dropchk = 0;  got_root = -1;
        u_a = LW'(pa[0]);  u_b = LW'(pb[0]);  u_valid = 1'b1;
        while ((pushed < 9 || seen == 0) && n < 1000) begin
            automatic bit acc = u_valid && u_ready;
            if (q_out_valid) begin seen = 1;  got_root = int'(q_root); end
            if (pushed == 8 && dropchk == 0) begin
                check("u_ready_full", u_ready, 0);
                dropchk = 1;
            end
            step();
            n++;
            if (acc) begin
                m_union(pa[pushed], pb[pushed]);
                pushed++;
                if (pushed < 9) begin u_a = LW'(pa[pushed]);  u_b = LW'(pb[pushed]); end
                else u_valid = 1'b0;
            end
        end
        u_valid = 1'b0;
        check("pushed_all", pushed, 9);
        check("deep_query_seen", seen, 1);
        check("deep_query_root", got_root, 0);
        wait_idle();
        do_query(9, r, lat);   check("requery9_lat", lat, 2);
        check("requery9_root", r, 0);
        query_all("fifo_root");

        do_union(1, 2);  do_union(3, 4);  do_union(2, 4);
        do_reset();
        query_all("after_abort_root");
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                do_union(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            end else begin
                automatic int l = int'($urandom_range(0, N - 1));
                do_query(l, r, lat);
                check("rand_root", r, m_root[l]);
            end
        end
        wait_idle();
        query_all("rand_final_root");
        run_flatten(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
